// File: rtl/sync_bits_filter.sv
// sync_bits_filter: per-bit multi-stage synchronizer with mismatch-count debounce
// and registered rise/fall/change pulses on the filtered output.
`ifndef BSV_ASSIGNMENT_DELAY
`define BSV_ASSIGNMENT_DELAY
`endif
module sync_bits_filter #(
    parameter int width = 1,
    parameter int stages = 2,
    parameter int filt = 0,
    parameter logic [width-1:0] init = {width{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [width-1:0] sD_IN,
    input  logic             dEN,
    output logic [width-1:0] dD_OUT,
    output logic [width-1:0] dRISE,
    output logic [width-1:0] dFALL,
    output logic             dCHG
);
    localparam int CW = (filt > 0) ? $clog2(filt + 1) : 1;

    logic [stages-1:0][width-1:0] sync_q;
    logic [width-1:0][CW-1:0] cnt_q, cnt_d;
    logic [width-1:0] out_q, out_d, rise_q, rise_d, fall_q, fall_d, sync_w, mis, fire;
    logic chg_q, chg_d;

    assign sync_w = sync_q[stages-1];

    for (genvar i = 0; i < width; i++) begin : g_ch
        assign mis[i]   = sync_w[i] ^ out_q[i];
        assign fire[i]  = dEN & mis[i] & (cnt_q[i] == CW'(filt));
        assign cnt_d[i] = !dEN ? cnt_q[i] : (mis[i] & !fire[i]) ? cnt_q[i] + CW'(1) : '0;
        assign out_d[i] = fire[i] ? sync_w[i] : out_q[i];
    end

    // out_d only differs from out_q when enabled, so disabled cycles yield no pulses
    assign rise_d = out_d & ~out_q;
    assign fall_d = ~out_d & out_q;
    assign chg_d  = |(rise_d | fall_d);

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            sync_q <= `BSV_ASSIGNMENT_DELAY {stages{init}};
            cnt_q  <= `BSV_ASSIGNMENT_DELAY '0;
            out_q  <= `BSV_ASSIGNMENT_DELAY init;
            rise_q <= `BSV_ASSIGNMENT_DELAY '0;
            fall_q <= `BSV_ASSIGNMENT_DELAY '0;
            chg_q  <= `BSV_ASSIGNMENT_DELAY 1'b0;
        end else begin
            sync_q <= `BSV_ASSIGNMENT_DELAY {sync_q[stages-2:0], sD_IN};
            cnt_q  <= `BSV_ASSIGNMENT_DELAY cnt_d;
            out_q  <= `BSV_ASSIGNMENT_DELAY out_d;
            rise_q <= `BSV_ASSIGNMENT_DELAY rise_d;
            fall_q <= `BSV_ASSIGNMENT_DELAY fall_d;
            chg_q  <= `BSV_ASSIGNMENT_DELAY chg_d;
        end

    assign dD_OUT = out_q;
    assign dRISE  = rise_q;
    assign dFALL  = fall_q;
    assign dCHG   = chg_q;
endmodule

// File: tb/tb_sync_bits_filter.sv
// tb_sync_bits_filter: four parameterisations driven with shared random stimulus
// and compared every cycle against a delay-line plus run-length reference model.
module tb_sync_bits_filter;
    logic CLK = 1'b0;
    logic RST;
    logic [3:0] sin;
    logic en;
    logic [3:0] qo[4], qr[4], qf[4];
    logic qc[4];
    logic [1:0] o2, r2, f2;
    int checks = 0;
    int errors = 0;

    int W[4] = '{4, 4, 2, 4};
    int S[4] = '{2, 2, 3, 2};
    int F[4] = '{0, 3, 0, 2};
    logic [3:0] I[4] = '{4'h0, 4'h0, 4'h0, 4'hA};

    logic [3:0] hist[4][8];
    logic [3:0] mo[4], mr[4], mf[4];
    logic mc[4];
    int run[4][4];

    always #5 CLK = ~CLK;

    sync_bits_filter #(.width(4), .stages(2), .filt(0), .init(4'h0)) u0 (
        .CLK(CLK), .RST(RST), .sD_IN(sin), .dEN(en),
        .dD_OUT(qo[0]), .dRISE(qr[0]), .dFALL(qf[0]), .dCHG(qc[0]));
    sync_bits_filter #(.width(4), .stages(2), .filt(3), .init(4'h0)) u1 (
        .CLK(CLK), .RST(RST), .sD_IN(sin), .dEN(en),
        .dD_OUT(qo[1]), .dRISE(qr[1]), .dFALL(qf[1]), .dCHG(qc[1]));
    sync_bits_filter #(.width(2), .stages(3), .filt(0), .init(2'b00)) u2 (
        .CLK(CLK), .RST(RST), .sD_IN(sin[1:0]), .dEN(en),
        .dD_OUT(o2), .dRISE(r2), .dFALL(f2), .dCHG(qc[2]));
    sync_bits_filter #(.width(4), .stages(2), .filt(2), .init(4'hA)) u3 (
        .CLK(CLK), .RST(RST), .sD_IN(sin), .dEN(en),
        .dD_OUT(qo[3]), .dRISE(qr[3]), .dFALL(qf[3]), .dCHG(qc[3]));

    assign qo[2] = {2'b00, o2};
    assign qr[2] = {2'b00, r2};
    assign qf[2] = {2'b00, f2};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] msk(input int d);
        return 4'hF >> (4 - W[d]);
    endfunction

    task automatic model_reset_one(input int d);
        for (int s = 0; s < 8; s++) hist[d][s] = I[d];
        mo[d] = I[d];
        mr[d] = '0;
        mf[d] = '0;
        mc[d] = 1'b0;
        for (int i = 0; i < 4; i++) run[d][i] = 0;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 4; d++) model_reset_one(d);
    endtask

    // One clock edge: the value at the end of the delay line is what the
    // debouncer sees; a change is accepted after filt+1 enabled mismatch cycles.
    task automatic model_edge();
        for (int d = 0; d < 4; d++) begin
            if (RST) model_reset_one(d);
            else begin
                logic [3:0] sv, nout;
                sv = hist[d][S[d]-1];
                nout = mo[d];
                for (int i = 0; i < W[d]; i++)
                    if (en) begin
                        if (sv[i] != mo[d][i]) begin
                            run[d][i]++;
                            if (run[d][i] == F[d] + 1) begin
                                nout[i] = sv[i];
                                run[d][i] = 0;
                            end
                        end else run[d][i] = 0;
                    end
                mr[d] = nout & ~mo[d];
                mf[d] = ~nout & mo[d];
                mc[d] = (mr[d] | mf[d]) != 4'h0;
                mo[d] = nout;
                for (int s = S[d] - 1; s > 0; s--) hist[d][s] = hist[d][s-1];
                hist[d][0] = sin & msk(d);
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("u%0d_out", d), 64'(qo[d]), 64'(mo[d]));
            chk($sformatf("u%0d_rise", d), 64'(qr[d]), 64'(mr[d]));
            chk($sformatf("u%0d_fall", d), 64'(qf[d]), 64'(mf[d]));
            chk($sformatf("u%0d_chg", d), 64'(qc[d]), 64'(mc[d]));
        end
    endtask

    initial begin
        RST = 1'b1;
        sin = 4'hF;
        en = 1'b1;
        model_reset();
        repeat (3) begin
            @(posedge CLK);
            model_edge();
            #1 check_all();
        end
        @(negedge CLK) RST = 1'b0;
        @(posedge CLK);
        model_edge();
        #1 check_all();
        for (int n = 0; n < 3000; n++) begin
            int rate;
            rate = (n / 500) % 3 == 0 ? 3 : (n / 500) % 3 == 1 ? 6 : 12;
            @(negedge CLK);
            if (RST) begin
                if ($urandom_range(0, 2) == 0) RST = 1'b0;
            end
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, rate - 1) == 0) sin[i] = ~sin[i];
            en = $urandom_range(0, 9) != 0;
            @(posedge CLK);
            model_edge();
            #1 check_all();
            if (!RST && $urandom_range(0, 199) == 0) begin
                #2 RST = 1'b1;
                #1 model_reset();
                check_all();
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_bits_filter.md
SYNC_BITS_FILTER -- requirements
Module: sync_bits_filter

Interface
REQ-001 The module SHALL have parameter width, default 1, giving the number of independent bit channels (legal 1..64).
REQ-002 The module SHALL have parameter stages, default 2, giving the synchronizer chain depth per channel (legal 2..8).
REQ-003 The module SHALL have parameter filt, default 0, giving the debounce length in cycles; 0 means no filtering (legal 0..255).
REQ-004 The module SHALL have parameter init, default {width{1'b0}}, giving the reset and initial value of every chain stage and of dD_OUT.
REQ-005 The module SHALL have port CLK, input, 1 bit: the single destination clock; all state is updated on posedge CLK.
REQ-006 The module SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-007 The module SHALL have port sD_IN, input, width bits: asynchronous data, one channel per bit.
REQ-008 The module SHALL have port dEN, input, 1 bit: filter and output update enable.
REQ-009 The module SHALL have port dD_OUT, output, width bits: the registered, filtered, synchronized value.
REQ-010 The module SHALL have port dRISE, output, width bits: a one-cycle pulse when the corresponding dD_OUT bit goes 0->1.
REQ-011 The module SHALL have port dFALL, output, width bits: a one-cycle pulse when the corresponding dD_OUT bit goes 1->0.
REQ-012 The module SHALL have port dCHG, output, 1 bit: a one-cycle pulse, equal to the OR of all dRISE and dFALL bits in the same cycle.

Function
REQ-013 Each channel SHALL capture sD_IN into a chain of stages registers shifting every CLK edge; sync[i] denotes the last stage; the chain SHALL shift regardless of dEN.
REQ-014 Only the first chain stage SHALL sample sD_IN; no logic SHALL sit between stages.
REQ-015 Each channel SHALL have a mismatch counter cnt[i] of width clog2(filt+1), minimum 1 bit.
REQ-016 With dEN=1 and sync[i]==dD_OUT[i], cnt[i] SHALL clear to 0 and dD_OUT[i] SHALL hold.
REQ-017 With dEN=1, sync[i]!=dD_OUT[i] and cnt[i]<filt, cnt[i] SHALL increment and dD_OUT[i] SHALL hold.
REQ-018 With dEN=1, sync[i]!=dD_OUT[i] and cnt[i]==filt, dD_OUT[i] SHALL load sync[i] and cnt[i] SHALL clear to 0.
REQ-019 Consequently, a level change first sampled at edge k and stable for filt+1 sampled cycles at sync[i] SHALL appear on dD_OUT[i] after edge k+stages+filt; with filt=0 this is after edge k+stages.
REQ-020 A mismatch shorter than filt+1 consecutive cycles at sync[i] SHALL produce no change on dD_OUT[i] and no pulse; the counter SHALL restart from 0 on the next mismatch.
REQ-021 dRISE[i] and dFALL[i] SHALL be registered and asserted in exactly the cycle following the edge on which dD_OUT[i] changes, then deasserted on the next edge unless a new change occurs.
REQ-022 Multiple channels changing on the same edge SHALL each pulse; dCHG SHALL assert once for that cycle.
REQ-023 With dEN=0, cnt, dD_OUT, dRISE, dFALL and dCHG SHALL hold the counter value and output values and drive all pulses to 0; a count in progress SHALL resume, not restart, when dEN returns to 1 if the mismatch persists.
REQ-024 cnt SHALL never exceed filt and SHALL never wrap.

Reset
REQ-025 RST=1 SHALL immediately (asynchronously) force every chain stage and dD_OUT to init, all cnt to 0, and dRISE, dFALL and dCHG to 0.
REQ-026 Reset mid-count or mid-pulse SHALL discard the count or pulse; no pulse SHALL be generated by reset itself or on reset release.
REQ-027 The first edge after RST deasserts SHALL resume normal operation.
REQ-028 Unless BSV_NO_INITIAL_BLOCKS is defined, simulation SHALL initialise all registers to the reset values; BSV_ASSIGNMENT_DELAY SHALL be applied to all sequential assignments.

Verification
REQ-029 Settings width=4, stages=2, filt=0, init=4'h0: assert RST with sD_IN=4'hF -> dD_OUT=4'h0, dRISE=0, dFALL=0, dCHG=0 throughout reset and the first edge after release.
REQ-030 Settings width=4, stages=2, filt=3: step sD_IN[0] 0->1, first sampled at edge k and held -> dD_OUT=4'h1 after edge k+5, dRISE=4'h1 and dCHG=1 for exactly one cycle.
REQ-031 Same settings: sD_IN[1] high for 3 sampled cycles, then low -> dD_OUT[1] stays 0, and dRISE and dCHG stay 0.
REQ-032 Same settings: step sD_IN[2] 0->1, drop dEN for 4 cycles after 2 mismatch cycles, then restore dEN -> dD_OUT[2] rises after 2 further enabled mismatch cycles, with one dRISE[2] pulse.
REQ-033 Same settings: assert RST asynchronously while cnt[3]=2, between edges -> dD_OUT and all cnt clear at once; after release, no pulse occurs until a full new filt+1 mismatch window.
REQ-034 Settings width=2, stages=3, filt=0: sD_IN 2'b00->2'b11 on one sampling edge k -> dD_OUT=2'b11 after edge k+3, dRISE=2'b11 and a single dCHG pulse.
